// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: FSM state encoding and default counter width shared by the scheduler files
package counter_sched_pkg;
  localparam int CW_DEFAULT = 8;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;
endpackage

// File: rtl/tick_counter.sv
// tick_counter: CW-bit interval count (clr/inc) and 32-bit wrapping run-cycle count (run); clk, async active-low rst_n
module tick_counter
  import counter_sched_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic          run,
  output logic [CW-1:0] count,
  output logic [31:0]   count_32
);
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   c32_q, c32_d;
  always_comb begin
    count_d = clr ? '0 : inc ? count_q + CW'(1) : count_q;
    c32_d   = run ? c32_q + 32'd1 : c32_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      c32_q   <= '0;
    end else begin
      count_q <= count_d;
      c32_q   <= c32_d;
    end
  end
  assign count    = count_q;
  assign count_32 = c32_q;
endmodule

// File: rtl/counter_scheduler.sv
// counter_scheduler: two-requester round-robin interval timer; REQ/LEN0/LEN1 in, GNT/DONE/BUSY/COUNT/COUNT_32BIT out; CLK, async active-low RESET
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [1:0]    REQ,
  input  logic [CW-1:0] LEN0,
  input  logic [CW-1:0] LEN1,
  output logic [1:0]    GNT,
  output logic [1:0]    DONE,
  output logic          BUSY,
  output logic [CW-1:0] COUNT,
  output logic [31:0]   COUNT_32BIT
);
  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [CW-1:0] target_q, target_d;
  logic          last_q, last_d;
  logic          win, req_g, clr, inc;
  assign win   = &REQ ? ~last_q : REQ[1] & ~REQ[0];
  assign req_g = |(REQ & gnt_q);
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    target_d = target_q;
    last_d   = last_q;
    clr      = 1'b0;
    inc      = 1'b0;
    case (state_q)
      IDLE: if (|REQ) begin
        state_d  = LOAD;
        gnt_d    = win ? 2'b10 : 2'b01;
        target_d = win ? LEN1 : LEN0;
        clr      = 1'b1;
      end
      LOAD, RUN: if (!req_g) begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        last_d  = gnt_q[1];
      end else if (state_q == LOAD) begin
        state_d = target_q == '0 ? FINISH : RUN;
      end else begin
        inc     = 1'b1;
        state_d = COUNT == target_q - CW'(1) ? FINISH : RUN;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        last_d  = gnt_q[1];
      end
    endcase
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      target_q <= '0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      target_q <= target_d;
      last_q   <= last_d;
    end
  end
  tick_counter #(.CW(CW)) u_tick (
    .clk      (CLK),
    .rst_n    (RESET),
    .clr      (clr),
    .inc      (inc),
    .run      (state_q == RUN),
    .count    (COUNT),
    .count_32 (COUNT_32BIT)
  );
  assign GNT  = gnt_q;
  assign DONE = state_q == FINISH ? gnt_q : 2'b00;
  assign BUSY = state_q == LOAD || state_q == RUN;
endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: directed and randomized checks of counter_scheduler against an interval-level model
module tb_counter_scheduler;
  logic       CLK = 0, RESET = 0;
  logic [1:0] REQ = 0;
  logic [7:0] LEN0 = 0, LEN1 = 0;
  logic [1:0] GNT, DONE;
  logic       BUSY;
  logic [7:0] COUNT;
  logic [31:0] COUNT_32BIT;
  int checks = 0, failures = 0;
  int n_gnt, max_cnt, at;
  logic [1:0] who;

  counter_scheduler #(.CW(8)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .LEN0(LEN0), .LEN1(LEN1),
    .GNT(GNT), .DONE(DONE), .BUSY(BUSY), .COUNT(COUNT), .COUNT_32BIT(COUNT_32BIT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an interval is described by who owns it, its target and how many edges
  // have elapsed since the granting edge (k). Everything else is derived from k.
  bit          m_act;
  int          m_who, m_tgt, m_k, m_hold;
  bit          m_last;
  logic [31:0] m_c32;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_act = 0; m_hold = 0; m_last = 1; m_c32 = 0; m_k = 0; m_tgt = 0; m_who = 0;
    end else if (m_act) begin
      if (m_k >= 1 && m_k <= m_tgt) m_c32 = m_c32 + 1;
      if (m_k <= m_tgt && !REQ[m_who]) begin
        m_act = 0; m_last = m_who[0]; m_hold = m_k == 0 ? 0 : m_k - 1;
      end else if (m_k == m_tgt + 1) begin
        m_act = 0; m_last = m_who[0]; m_hold = m_tgt;
      end else m_k++;
    end else if (REQ != 0) begin
      m_who = REQ == 2'b11 ? (m_last ? 0 : 1) : (REQ[1] ? 1 : 0);
      m_tgt = m_who == 1 ? int'(LEN1) : int'(LEN0);
      m_k = 0; m_act = 1;
    end
  end

  always @(negedge CLK) begin
    if (RESET) begin
      chk("gnt",   GNT,   m_act ? (1 << m_who) : 0);
      chk("done",  DONE,  (m_act && m_k == m_tgt + 1) ? (1 << m_who) : 0);
      chk("busy",  BUSY,  m_act && m_k <= m_tgt);
      chk("count", COUNT, m_act ? (m_k == 0 ? 0 : m_k - 1) : m_hold);
      chk("c32",   COUNT_32BIT, m_c32);
    end
  end

  task automatic step();
    @(negedge CLK); #2;
  endtask

  task automatic do_reset();
    step(); RESET = 0; REQ = 0; step(); RESET = 1;
  endtask

  // Steps until DONE fires (dropping that request), counting edges since the drive point.
  task automatic run_until_done(input int max, output int t, output logic [1:0] w);
    t = -1; w = 0; n_gnt = 0; max_cnt = 0;
    for (int i = 1; i <= max; i++) begin
      step();
      if (GNT != 0) n_gnt++;
      if (int'(COUNT) > max_cnt) max_cnt = COUNT;
      if (DONE != 0) begin t = i; w = DONE; REQ = REQ & ~DONE; break; end
    end
    if (t < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    RESET = 0;
    #1 chk("rst_gnt", GNT, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_c32", COUNT_32BIT, 0);
    chk("rst_busy", BUSY, 0);
    do_reset();
    // single requester, LEN0=5
    REQ = 2'b01; LEN0 = 5;
    run_until_done(20, at, who);
    chk("a_done_at", at, 7); chk("a_done_who", who, 1); chk("a_max_cnt", max_cnt, 5);
    for (int i = 0; i < 3; i++) begin step(); if (GNT != 0) n_gnt++; end
    chk("a_gnt_cycles", n_gnt, 7); chk("a_c32", COUNT_32BIT, 5);
    // both requesting from reset
    do_reset();
    REQ = 2'b11; LEN0 = 3; LEN1 = 4;
    run_until_done(20, at, who);
    chk("b_first_at", at, 5); chk("b_first_who", who, 1);
    run_until_done(20, at, who);
    chk("b_second_at", at, 7); chk("b_second_who", who, 2);
    step(); chk("b_c32", COUNT_32BIT, 7);
    // zero length
    do_reset();
    REQ = 2'b01; LEN0 = 0;
    run_until_done(10, at, who);
    chk("c_done_at", at, 2); chk("c_c32", COUNT_32BIT, 0);
    // abort at COUNT=4, then tie goes to req0
    do_reset();
    REQ = 2'b10; LEN1 = 10;
    for (int i = 0; i < 30 && COUNT != 4; i++) step();
    LEN1 = 1;
    REQ = 2'b00; step();
    chk("d_gnt", GNT, 0); chk("d_done", DONE, 0); chk("d_count", COUNT, 4);
    REQ = 2'b11; LEN0 = 2; step();
    chk("d_tie", GNT, 1);
    REQ = 2'b00; step(); step();
    // async reset mid-RUN
    REQ = 2'b01; LEN0 = 10;
    for (int i = 0; i < 30 && COUNT != 3; i++) step();
    RESET = 0; #1;
    chk("e_gnt", GNT, 0); chk("e_done", DONE, 0); chk("e_busy", BUSY, 0);
    chk("e_count", COUNT, 0); chk("e_c32", COUNT_32BIT, 0);
    REQ = 2'b00; step(); RESET = 1;
    REQ = 2'b01; LEN0 = 2;
    run_until_done(20, at, who);
    chk("e_done_at", at, 4);
    // full range
    do_reset();
    REQ = 2'b01; LEN0 = 255;
    run_until_done(300, at, who);
    chk("f_done_at", at, 257); chk("f_count", COUNT, 255); chk("f_c32", COUNT_32BIT, 255);
    // randomized traffic including length changes mid-interval and stray resets
    for (int i = 0; i < 4000; i++) begin
      step();
      if ($urandom_range(99) < 25) REQ = 2'($urandom);
      if ($urandom_range(99) < 30) LEN0 = $urandom_range(99) < 5 ? 8'($urandom) : 8'($urandom_range(6));
      if ($urandom_range(99) < 30) LEN1 = $urandom_range(99) < 5 ? 8'($urandom) : 8'($urandom_range(6));
      if ($urandom_range(999) == 0) begin RESET = 0; #1 RESET = 1; end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
